// File: rtl/dcache_ctrl.sv
// dcache_ctrl - direct-mapped, write-through, no-write-allocate data cache
// controller for the memory stage of a pipelined RV32 core.
//
// Each of the 2^SET_BITS lines holds one word with a valid bit and a tag.
// Load hits complete in the request cycle. A load miss or any store talks
// to a multi-cycle backing memory over a req/ready handshake while `stall`
// freezes the pipeline.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_re / cpu_we          load / store request (both set = store)
//   cpu_addr, cpu_wdata      byte address (bits [1:0] ignored), store data
//   cpu_rdata                load data, valid when cpu_re=1 and stall=0
//   stall                    pipeline hold
//   mem_req, mem_we          backing-memory request and write qualifier
//   mem_addr, mem_wdata      word-aligned address and write data (latched)
//   mem_ready, mem_rdata     one-cycle completion pulse and read data
//   hit_count, miss_count    saturating load hit / miss counters
module dcache_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = DATA_WIDTH - SET_BITS - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMISS = 2'd1,
        WTHRU = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Line storage: only the valid bits are reset.
    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS];

    // Latched request, held as a word address so mem_addr is always aligned.
    logic [DATA_WIDTH-3:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] resp_q;
    logic [CNT_WIDTH-1:0]  hit_cnt_q;
    logic [CNT_WIDTH-1:0]  miss_cnt_q;

    logic [SET_BITS-1:0] cpu_idx;
    logic [TAG_W-1:0]    cpu_tag;
    logic [SET_BITS-1:0] lat_idx;
    logic [TAG_W-1:0]    lat_tag;
    logic                cpu_hit;
    logic                lat_hit;
    logic                req_load;
    logic                launch;
    logic                unused_addr_bits;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cpu_idx = cpu_addr[SET_BITS+1:2];
    assign cpu_tag = cpu_addr[DATA_WIDTH-1:SET_BITS+2];
    assign lat_idx = waddr_q[SET_BITS-1:0];
    assign lat_tag = waddr_q[DATA_WIDTH-3:SET_BITS];
    // Byte offset within the word plays no role in a word-granular cache.
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    // Write-through hit check uses the latched address, not the live bus.
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    // A combined read+write request is a store.
    assign req_load = cpu_re && !cpu_we;
    assign launch   = (state_q == IDLE) && (cpu_we || (req_load && !cpu_hit));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_we) begin
                    state_d = WTHRU;
                end else if (cpu_re && !cpu_hit) begin
                    state_d = RMISS;
                end
            end
            RMISS:   if (mem_ready) state_d = RESP;
            WTHRU:   if (mem_ready) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall     = 1'b0;
        mem_req   = 1'b0;
        cpu_rdata = '0;
        case (state_q)
            IDLE: begin
                // Miss/store detection stalls in the same cycle.
                stall = launch;
                if (req_load && cpu_hit) begin
                    cpu_rdata = data_q[cpu_idx];
                end
            end
            RMISS, WTHRU: begin
                stall   = 1'b1;
                mem_req = 1'b1;
            end
            RESP: begin
                cpu_rdata = resp_q;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign mem_we     = we_q;
    assign mem_addr   = {waddr_q, 2'b00};
    assign mem_wdata  = wdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Request latches, valid bits, response capture and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            resp_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (launch) begin
                waddr_q <= cpu_addr[DATA_WIDTH-1:2];
                wdata_q <= cpu_wdata;
                we_q    <= cpu_we;
            end
            // Only fresh requests in IDLE are counted; RESP sees the held
            // request again and must not count it twice.
            if (state_q == IDLE && req_load) begin
                if (cpu_hit) begin
                    hit_cnt_q <= sat_inc(hit_cnt_q);
                end else begin
                    miss_cnt_q <= sat_inc(miss_cnt_q);
                end
            end
            if (state_q == RMISS && mem_ready) begin
                valid_q[lat_idx] <= 1'b1;
                resp_q           <= mem_rdata;
            end
            if (state_q == WTHRU && mem_ready) begin
                we_q <= 1'b0;
            end
        end
    end

    // Tag and data arrays; a reset in flight suppresses the line write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RMISS && mem_ready) begin
            tag_q[lat_idx]  <= lat_tag;
            data_q[lat_idx] <= mem_rdata;
        end else if (!rst && state_q == WTHRU && mem_ready && lat_hit) begin
            data_q[lat_idx] <= wdata_q;
        end
    end

endmodule
